// File: rtl/fu_mc.sv
// rtl/fu_mc.sv - function unit with single-cycle ALU ops and iterative multiply/shift
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready  request handshake; a_in, b_in, fs_in captured on accept
//   out_valid/out_ready result handshake; f_out plus z/n/c/v flags registered
//   busy_out           high while a multi-cycle op iterates
module fu_mc #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [3:0]       fs_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f_out,
  output logic             z_out,
  output logic             n_out,
  output logic             c_out,
  output logic             v_out,
  output logic             busy_out
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;
  localparam int M  = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_nx;

  logic [3:0]         op;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [SW-1:0]      shamt;
  logic               accept, multi;

  logic [WIDTH:0]     sum, dif, inc, dec;
  logic [WIDTH-1:0]   res_f;
  logic               res_c, res_v;

  logic [WIDTH:0]     hi_sum;
  logic [2*WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0]   step_f;
  logic               step_c;

  assign shamt     = b_in[SW-1:0];
  assign in_ready  = !rst && (state == IDLE || (state == DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy_out  = (state == EXEC);

  // A shift by zero has nothing to iterate, so it completes like a single-cycle op.
  assign multi = ((fs_in == 4'b1100) && MUL_EN) ||
                 (((fs_in == 4'b1101) || (fs_in == 4'b1110)) && (shamt != '0));

  assign sum = {1'b0, a_in} + {1'b0, b_in};
  assign dif = {1'b0, a_in} - {1'b0, b_in};
  assign inc = {1'b0, a_in} + (WIDTH+1)'(1);
  assign dec = {1'b0, a_in} - (WIDTH+1)'(1);

  always_comb begin
    res_f = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (fs_in)
      4'b0000: res_f = a_in;
      4'b0001: begin
        res_f = inc[M:0];
        res_c = inc[WIDTH];
        res_v = ~a_in[M] & inc[M];
      end
      4'b0010: begin
        res_f = sum[M:0];
        res_c = sum[WIDTH];
        res_v = (a_in[M] == b_in[M]) && (sum[M] != a_in[M]);
      end
      4'b0011: begin
        res_f = dif[M:0];
        res_c = ~dif[WIDTH];
        res_v = (a_in[M] != b_in[M]) && (dif[M] != a_in[M]);
      end
      4'b0100: begin
        res_f = dec[M:0];
        res_c = ~dec[WIDTH];
        res_v = a_in[M] & ~dec[M];
      end
      4'b0101: res_f = a_in & b_in;
      4'b0110: res_f = a_in | b_in;
      4'b0111: res_f = a_in ^ b_in;
      4'b1000: res_f = ~a_in;
      4'b1001: res_f = b_in;
      4'b1010: begin
        res_f = {b_in[M-1:0], 1'b0};
        res_c = b_in[M];
      end
      4'b1011: begin
        res_f = {1'b0, b_in[M:1]};
        res_c = b_in[0];
      end
      4'b1101, 4'b1110: res_f = a_in;  // only reached with shamt == 0
      default: res_f = '0;             // reserved, or MUL when disabled
    endcase
  end

  // One iteration step. For MUL, acc holds {partial product high, multiplier};
  // each step conditionally adds the multiplicand into the high half and shifts
  // right, so after WIDTH steps acc is the full 2*WIDTH-bit product.
  always_comb begin
    hi_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    acc_nx = acc;
    step_c = 1'b0;
    case (op)
      4'b1100: begin
        acc_nx = {hi_sum, acc[M:1]};
        step_c = |acc_nx[2*WIDTH-1:WIDTH];
      end
      4'b1101: begin
        acc_nx = {acc[2*WIDTH-1:WIDTH], acc[M-1:0], 1'b0};
        step_c = acc[M];
      end
      4'b1110: begin
        acc_nx = {acc[2*WIDTH-1:WIDTH], 1'b0, acc[M:1]};
        step_c = acc[0];
      end
      default: acc_nx = acc;
    endcase
    step_f = acc_nx[M:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = multi ? EXEC : DONE;
      EXEC: if (cnt == CW'(1)) state_nx = DONE;
      DONE: if (out_ready) state_nx = accept ? (multi ? EXEC : DONE) : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op    <= '0;
      cnt   <= '0;
      acc   <= '0;
      mcand <= '0;
      f_out <= '0;
      z_out <= 1'b0;
      n_out <= 1'b0;
      c_out <= 1'b0;
      v_out <= 1'b0;
    end else if (accept) begin
      op <= fs_in;
      if (multi) begin
        mcand <= a_in;
        if (fs_in == 4'b1100) begin
          cnt <= CW'(WIDTH);
          acc <= {{WIDTH{1'b0}}, b_in};
        end else begin
          cnt <= CW'(shamt);
          acc <= {{WIDTH{1'b0}}, a_in};
        end
      end else begin
        f_out <= res_f;
        z_out <= (res_f == '0);
        n_out <= res_f[M];
        c_out <= res_c;
        v_out <= res_v;
      end
    end else if (state == EXEC) begin
      acc <= acc_nx;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        f_out <= step_f;
        z_out <= (step_f == '0);
        n_out <= step_f[M];
        c_out <= step_c;
        v_out <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fu_mc.sv
// tb/tb_fu_mc.sv - self-checking bench for fu_mc: vector table, directed sequences, random vs model
module tb_fu_mc;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic [3:0]   fs_in = '0;
  logic         in_ready, out_valid, z_out, n_out, c_out, v_out, busy_out;
  logic [W-1:0] f_out;

  int n_vec = 0;
  int n_err = 0;

  fu_mc #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .fs_in(fs_in), .out_valid(out_valid),
    .out_ready(out_ready), .f_out(f_out), .z_out(z_out), .n_out(n_out),
    .c_out(c_out), .v_out(v_out), .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  fs;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] f;
    logic [3:0]  fl;   // {z, n, c, v}
    int          lat;
  } vec_t;

  vec_t vt [21] = '{
    '{4'h2, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 1},
    '{4'h3, 16'h0005, 16'h0005, 16'h0000, 4'b1010, 1},
    '{4'h3, 16'h0000, 16'h0001, 16'hFFFF, 4'b0100, 1},
    '{4'hC, 16'h00FF, 16'h0101, 16'hFFFF, 4'b0100, 17},
    '{4'hC, 16'h0100, 16'h0100, 16'h0000, 4'b1010, 17},
    '{4'hD, 16'h0001, 16'h000F, 16'h8000, 4'b0100, 16},
    '{4'hE, 16'h8001, 16'h0000, 16'h8001, 4'b0100, 1},
    '{4'h1, 16'hFFFF, 16'h0000, 16'h0000, 4'b1010, 1},
    '{4'h4, 16'h8000, 16'h0000, 16'h7FFF, 4'b0011, 1},
    '{4'h4, 16'h0000, 16'h0000, 16'hFFFF, 4'b0100, 1},
    '{4'h5, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 1},
    '{4'h8, 16'h00FF, 16'h0000, 16'hFF00, 4'b0100, 1},
    '{4'hA, 16'h0000, 16'h8001, 16'h0002, 4'b0010, 1},
    '{4'hB, 16'h0000, 16'h0003, 16'h0001, 4'b0010, 1},
    '{4'hF, 16'h1234, 16'h5678, 16'h0000, 4'b1000, 1},
    '{4'hE, 16'h8008, 16'h0004, 16'h0800, 4'b0010, 5},
    '{4'h9, 16'h0000, 16'hABCD, 16'hABCD, 4'b0100, 1},
    '{4'hD, 16'h0003, 16'h0011, 16'h0006, 4'b0000, 2},
    '{4'h6, 16'h1200, 16'h0034, 16'h1234, 4'b0000, 1},
    '{4'h2, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 1},
    '{4'hD, 16'h8001, 16'h0001, 16'h0002, 4'b0010, 2}
  };

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: results straight from the arithmetic definition of each op.
  function automatic void model(input logic [3:0] fs, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] f, output logic c, output logic v,
                                output int lat);
    int ia, ib, sa, sb, sh, r, s;
    longint p;
    ia = int'(a); ib = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    sh = ib % 16;
    r = 0; c = 1'b0; v = 1'b0; lat = 1;
    case (fs)
      4'h0: r = ia;
      4'h1: begin r = ia + 1; c = (r > 65535); v = ((sa + 1) > 32767); end
      4'h2: begin r = ia + ib; c = (r > 65535); s = sa + sb; v = (s > 32767) || (s < -32768); end
      4'h3: begin r = ia - ib; c = (ia >= ib); s = sa - sb; v = (s > 32767) || (s < -32768); end
      4'h4: begin r = ia - 1; c = (ia >= 1); v = ((sa - 1) < -32768); end
      4'h5: r = ia & ib;
      4'h6: r = ia | ib;
      4'h7: r = ia ^ ib;
      4'h8: r = ~ia;
      4'h9: r = ib;
      4'hA: begin r = ib * 2; c = (ib >= 32768); end
      4'hB: begin r = ib / 2; c = ((ib % 2) == 1); end
      4'hC: begin p = longint'(ia) * longint'(ib); r = int'(p % 65536); c = (p >= 65536); lat = 17; end
      4'hD: begin r = ia << sh; c = (sh != 0) && (((ia >> (16 - sh)) & 1) == 1); lat = sh + 1; end
      4'hE: begin r = ia >> sh; c = (sh != 0) && (((ia >> (sh - 1)) & 1) == 1); lat = sh + 1; end
      default: r = 0;
    endcase
    f = r[15:0];
  endfunction

  task automatic run_op(input logic [3:0] fs, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] f, output logic [3:0] fl, output int lat,
                        output bit exec_ok);
    int waitc;
    waitc = 0;
    @(negedge clk);
    while (!in_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    chk("in_ready_before_issue", 64'(in_ready), 64'(1));
    fs_in = fs; a_in = a; b_in = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    fs_in = 4'($urandom); a_in = 16'($urandom); b_in = 16'($urandom);
    lat = 0;
    exec_ok = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
      if (!busy_out || in_ready) exec_ok = 1'b0;
    end
    f = f_out;
    fl = {z_out, n_out, c_out, v_out};
    if (lat != 0) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] f, ef;
    logic [3:0]  fl, fs;
    logic [15:0] a, b;
    logic        ec, ev;
    int          lat, elat;
    bit          ok;
    logic [19:0] snap;

    #2;
    chk("reset_outputs", 64'({f_out, z_out, n_out, c_out, v_out, out_valid, busy_out, in_ready}), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("in_ready_after_reset", 64'(in_ready), 64'(1));

    for (int i = 0; i < 21; i++) begin
      run_op(vt[i].fs, vt[i].a, vt[i].b, f, fl, lat, ok);
      chk($sformatf("vec%0d_f", i), 64'(f), 64'(vt[i].f));
      chk($sformatf("vec%0d_flags", i), 64'(fl), 64'(vt[i].fl));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vt[i].lat));
      chk($sformatf("vec%0d_exec_handshake", i), 64'(ok), 64'(1));
    end

    // Backpressure, then a new op accepted in the same cycle the result is taken.
    @(negedge clk);
    fs_in = 4'h2; a_in = 16'h1234; b_in = 16'h1111; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_valid", 64'(out_valid), 64'(1));
    chk("bp_f", 64'(f_out), 64'(16'h2345));
    snap = {f_out, z_out, n_out, c_out, v_out};
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if ({f_out, z_out, n_out, c_out, v_out} !== snap || !out_valid) ok = 1'b0;
    end
    chk("bp_hold_stable", 64'(ok), 64'(1));
    out_ready = 1'b1; in_valid = 1'b1;
    fs_in = 4'h7; a_in = 16'hF0F0; b_in = 16'h0FF0;
    #1;
    chk("bp_in_ready_follows_out_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("b2b_valid_no_gap", 64'(out_valid), 64'(1));
    chk("b2b_xor_f", 64'(f_out), 64'(16'hFF00));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Reset in the middle of a multiply.
    @(negedge clk);
    fs_in = 4'hC; a_in = 16'h1234; b_in = 16'h5678; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("mul_busy_before_reset", 64'(busy_out), 64'(1));
    rst = 1'b1;
    #1;
    chk("abort_outputs", 64'({f_out, z_out, n_out, c_out, v_out, out_valid, busy_out, in_ready}), 64'(0));
    @(posedge clk);
    #1;
    chk("abort_held", 64'({f_out, out_valid, busy_out, in_ready}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (out_valid || busy_out) ok = 1'b0;
    end
    chk("abort_no_result", 64'(ok), 64'(1));
    chk("abort_f_cleared", 64'(f_out), 64'(0));
    run_op(4'h2, 16'h0002, 16'h0003, f, fl, lat, ok);
    chk("post_reset_add_f", 64'(f), 64'(16'h0005));
    chk("post_reset_add_flags", 64'(fl), 64'(4'b0000));
    chk("post_reset_add_latency", 64'(lat), 64'(1));

    // Random ops against the reference model.
    repeat (150) begin
      fs = 4'($urandom_range(0, 15));
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 3) == 0) a = 16'h8000;
      if ($urandom_range(0, 3) == 0) b = 16'hFFFF;
      model(fs, a, b, ef, ec, ev, elat);
      run_op(fs, a, b, f, fl, lat, ok);
      chk($sformatf("rand_op%0h_a%0h_b%0h_f", fs, a, b), 64'(f), 64'(ef));
      chk($sformatf("rand_op%0h_a%0h_b%0h_flags", fs, a, b), 64'(fl),
          64'({ef == 16'h0000, ef[15], ec, ev}));
      chk($sformatf("rand_op%0h_latency", fs), 64'(lat), 64'(elat));
      chk($sformatf("rand_op%0h_exec_handshake", fs), 64'(ok), 64'(1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
